// File: rtl/dspl_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: digit count,
// active-low segment type and the hex-to-segment table (bit 6 = a ... bit 0 = g).
package dspl_pkg;

    localparam int DIGIT_NUM = 32'd8;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_BLANK = 8'hFF;

    localparam seg7_t SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic seg7_t hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/dspl_scan_if.sv
// Load bus and display pins of the scanner; master = host side, slave = scanner.
interface dspl_scan_if;
    import dspl_pkg::*;

    logic                 load_i;
    logic [31:0]          value_i;
    logic [DIGIT_NUM-1:0] dp_i;
    logic [DIGIT_NUM-1:0] enable_i;
    logic                 frame_o;
    logic                 dspl_a;
    logic                 dspl_b;
    logic                 dspl_c;
    logic                 dspl_d;
    logic                 dspl_e;
    logic                 dspl_f;
    logic                 dspl_g;
    logic                 dspl_p;
    logic [DIGIT_NUM-1:0] dspl_an;

    modport master (
        output load_i, value_i, dp_i, enable_i,
        input  frame_o, dspl_a, dspl_b, dspl_c, dspl_d, dspl_e, dspl_f, dspl_g,
               dspl_p, dspl_an
    );

    modport slave (
        input  load_i, value_i, dp_i, enable_i,
        output frame_o, dspl_a, dspl_b, dspl_c, dspl_d, dspl_e, dspl_f, dspl_g,
               dspl_p, dspl_an
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_decode
    import dspl_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/dspl_scan.sv
// Eight-digit seven-segment scanner with frame-synchronous double-buffered load.
// Optional macro DSPL_DP_EN enables decimal-point storage and drive.
module dspl_scan
    import dspl_pkg::seg7_t, dspl_pkg::SEG_BLANK;
#(
    parameter int HALF_MS_COUNT = 32'd50000,
    parameter int DIGIT_NUM     = 32'd8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dspl_scan_if.slave  bus
);

    localparam int PW = (HALF_MS_COUNT > 32'd1) ? $clog2(HALF_MS_COUNT) : 32'd1;
    localparam int IW = $clog2(DIGIT_NUM);
    localparam logic [PW-1:0] PRESC_LAST = PW'(HALF_MS_COUNT - 32'd1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGIT_NUM - 32'd1);
    localparam logic [DIGIT_NUM-1:0] AN_OFF = {DIGIT_NUM{1'b1}};

    logic [PW-1:0]          presc_r;
    logic [IW-1:0]          idx_r;
    logic                   tick_s;
    logic                   boundary_s;

    logic [4*DIGIT_NUM-1:0] pend_val_r;
    logic [4*DIGIT_NUM-1:0] act_val_r;
    logic [DIGIT_NUM-1:0]   pend_en_r;
    logic [DIGIT_NUM-1:0]   act_en_r;
    logic                   pend_flag_r;

    logic [3:0]             nibble_s;
    seg7_t                  seg_s;
    logic                   dp_on_s;
    logic                   lit_s;

    logic [DIGIT_NUM-1:0]   an_nxt_s;
    seg7_t                  seg_nxt_s;
    logic                   p_nxt_s;

    logic [DIGIT_NUM-1:0]   an_r;
    seg7_t                  seg_r;
    logic                   p_r;
    logic                   frame_r;

    assign tick_s     = (presc_r == PRESC_LAST);
    assign boundary_s = tick_s && (idx_r == IDX_LAST);

    // Dwell prescaler and digit index; the index moves on every tick
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= idx_r + IW'(1'b1);
        end else begin
            presc_r <= presc_r + PW'(1'b1);
        end
    end

    // Pending/active hand-off: active only changes on the frame boundary so a frame never tears
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_val_r  <= '0;
            pend_en_r   <= '0;
            act_val_r   <= '0;
            act_en_r    <= '0;
            pend_flag_r <= 1'b0;
        end else if (boundary_s) begin
            if (bus.load_i) begin
                act_val_r <= bus.value_i;
                act_en_r  <= bus.enable_i;
            end else if (pend_flag_r) begin
                act_val_r <= pend_val_r;
                act_en_r  <= pend_en_r;
            end
            pend_flag_r <= 1'b0;
        end else if (bus.load_i) begin
            pend_val_r  <= bus.value_i;
            pend_en_r   <= bus.enable_i;
            pend_flag_r <= 1'b1;
        end
    end

`ifdef DSPL_DP_EN
    logic [DIGIT_NUM-1:0] pend_dp_r;
    logic [DIGIT_NUM-1:0] act_dp_r;

    // Decimal-point bits follow the same pending/active hand-off as the digit data
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_dp_r <= '0;
            act_dp_r  <= '0;
        end else if (boundary_s) begin
            if (bus.load_i) begin
                act_dp_r <= bus.dp_i;
            end else if (pend_flag_r) begin
                act_dp_r <= pend_dp_r;
            end
        end else if (bus.load_i) begin
            pend_dp_r <= bus.dp_i;
        end
    end

    assign dp_on_s = act_dp_r[idx_r];
`else
    logic unused_dp_s;
    assign unused_dp_s = ^bus.dp_i;
    assign dp_on_s     = 1'b0;
`endif

    assign nibble_s = act_val_r[{idx_r, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .nibble (nibble_s),
        .seg    (seg_s)
    );

    // Next display state: the edge that carries a tick loads the blank guard pattern
    always_comb begin
        lit_s     = 1'b0;
        an_nxt_s  = AN_OFF;
        seg_nxt_s = SEG_BLANK;
        p_nxt_s   = 1'b1;
        if (!tick_s && act_en_r[idx_r]) begin
            lit_s     = 1'b1;
            an_nxt_s  = ~(DIGIT_NUM'(1'b1) << idx_r);
            seg_nxt_s = seg_s;
            p_nxt_s   = ~dp_on_s;
        end else begin
            lit_s     = 1'b0;
            an_nxt_s  = AN_OFF;
            seg_nxt_s = SEG_BLANK;
            p_nxt_s   = 1'b1;
        end
    end

    // Registered pin drivers and the frame-start pulse
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            an_r    <= AN_OFF;
            seg_r   <= SEG_BLANK;
            p_r     <= 1'b1;
            frame_r <= 1'b0;
        end else begin
            an_r    <= an_nxt_s;
            seg_r   <= seg_nxt_s;
            p_r     <= p_nxt_s;
            frame_r <= boundary_s;
        end
    end

    assign bus.dspl_an = an_r;
    assign {bus.dspl_a, bus.dspl_b, bus.dspl_c, bus.dspl_d,
            bus.dspl_e, bus.dspl_f, bus.dspl_g} = seg_r;
    assign bus.dspl_p  = p_r;
    assign bus.frame_o = frame_r;

endmodule

// File: tb/tb_dspl_scan.sv
// Scoreboard bench for dspl_scan: a frame/dwell arithmetic model predicts every
// cycle's pins, a negedge monitor compares them.
module tb_dspl_scan;

    localparam int H     = 5;
    localparam int FRAME = 8 * H;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       p;
        logic       fr;
    } exp_t;

    typedef struct {
        int          eff;
        logic [31:0] v;
        logic [7:0]  en;
        logic [7:0]  dp;
    } ld_t;

    logic clk_i = 1'b0;
    logic rst_i;

    exp_t exp_q [$];
    ld_t  loads [$];
    exp_t mon_x;
    logic [6:0] seg_ref [16];
    int   e        = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_i = ~clk_i;

    dspl_scan_if bus ();

    dspl_scan #(
        .HALF_MS_COUNT (H),
        .DIGIT_NUM     (8)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, expv);
        end
    endtask

    // Edge ed counts rising edges since reset release; a dwell is H edges, a frame 8 dwells.
    function automatic exp_t model(input int ed);
        exp_t r;
        ld_t  cur;
        bit   have;
        int   idx;
        r.an  = 8'hFF;
        r.seg = 7'h7F;
        r.p   = 1'b1;
        r.fr  = (ed % FRAME == 0);
        if (ed % H != 0) begin
            have = 1'b0;
            foreach (loads[i]) begin
                if (loads[i].eff <= ed) begin
                    cur  = loads[i];
                    have = 1'b1;
                end
            end
            idx = (ed / H) % 8;
            if (have && cur.en[idx]) begin
                r.an  = ~(8'd1 << idx);
                r.seg = seg_ref[cur.v[idx*4 +: 4]];
`ifdef DSPL_DP_EN
                r.p   = ~cur.dp[idx];
`endif
            end
        end
        return r;
    endfunction

    task automatic cycle(input bit ld, input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
        ld_t l;
        bus.load_i   = ld;
        bus.value_i  = v;
        bus.enable_i = en;
        bus.dp_i     = dp;
        @(posedge clk_i);
        e++;
        if (ld) begin
            l.eff = ((e + FRAME - 1) / FRAME) * FRAME;
            l.v   = v;
            l.en  = en;
            l.dp  = dp;
            loads.push_back(l);
        end
        #2;
        exp_q.push_back(model(e));
        bus.load_i = 1'b0;
    endtask

    task automatic idle_to(input int target);
        while (e < target) cycle(1'b0, $urandom, 8'($urandom), 8'($urandom));
    endtask

    task automatic load_at(input int edge_n, input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
        idle_to(edge_n - 1);
        cycle(1'b1, v, en, dp);
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_an"},    {24'd0, bus.dspl_an}, 32'h0000_00FF);
        chk({tag, "_seg"},   {25'd0, bus.dspl_a, bus.dspl_b, bus.dspl_c, bus.dspl_d,
                              bus.dspl_e, bus.dspl_f, bus.dspl_g}, 32'h0000_007F);
        chk({tag, "_p"},     {31'd0, bus.dspl_p}, 32'd1);
        chk({tag, "_frame"}, {31'd0, bus.frame_o}, 32'd0);
    endtask

    // Monitor: compare the pins against the oldest prediction, mid-cycle
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            chk("an", {24'd0, bus.dspl_an}, {24'd0, mon_x.an});
            chk("seg", {25'd0, bus.dspl_a, bus.dspl_b, bus.dspl_c, bus.dspl_d,
                        bus.dspl_e, bus.dspl_f, bus.dspl_g}, {25'd0, mon_x.seg});
            chk("dp", {31'd0, bus.dspl_p}, {31'd0, mon_x.p});
            chk("frame", {31'd0, bus.frame_o}, {31'd0, mon_x.fr});
        end
    end

    initial begin
        int b;
        seg_ref[0]  = 7'b0000001; seg_ref[1]  = 7'b1001111;
        seg_ref[2]  = 7'b0010010; seg_ref[3]  = 7'b0000110;
        seg_ref[4]  = 7'b1001100; seg_ref[5]  = 7'b0100100;
        seg_ref[6]  = 7'b0100000; seg_ref[7]  = 7'b0001111;
        seg_ref[8]  = 7'b0000000; seg_ref[9]  = 7'b0000100;
        seg_ref[10] = 7'b0001000; seg_ref[11] = 7'b1100000;
        seg_ref[12] = 7'b0110001; seg_ref[13] = 7'b1000010;
        seg_ref[14] = 7'b0110000; seg_ref[15] = 7'b0111000;

        bus.load_i   = 1'b0;
        bus.value_i  = 32'd0;
        bus.enable_i = 8'd0;
        bus.dp_i     = 8'd0;
        rst_i        = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_blank("reset");
        #1;
        rst_i = 1'b1;

        // Blank scan with frame pulses only
        idle_to(3 * FRAME);
        // Counting pattern, all digits enabled
        load_at(125, 32'h7654_3210, 8'hFF, 8'h00);
        idle_to(5 * FRAME);
        // Two loads in one frame: last wins, current frame untouched
        load_at(5 * FRAME + 17, 32'h1111_1111, 8'hFF, 8'h00);
        load_at(5 * FRAME + 27, 32'h2222_2222, 8'hFF, 8'h00);
        idle_to(7 * FRAME);
        // Load coincident with the boundary tick
        load_at(8 * FRAME, 32'hFFFF_FFFF, 8'hFF, 8'h00);
        idle_to(9 * FRAME);
        // Partial enable with a decimal point on digit 0
        load_at(9 * FRAME + 3, 32'h7654_3210, 8'b0000_0101, 8'h01);
        idle_to(12 * FRAME);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                cycle(1'b1, $urandom, 8'($urandom), 8'($urandom));
            else
                cycle(1'b0, $urandom, 8'($urandom), 8'($urandom));
        end

        // Reset mid-dwell of digit 4 while a pending load is in flight
        b = ((e / FRAME) + 1) * FRAME;
        load_at(b, 32'h89AB_CDEF, 8'hFF, 8'hFF);
        load_at(b + 22, 32'h1234_5678, 8'hFF, 8'hFF);
        bus.load_i  = 1'b1;
        bus.value_i = 32'h5555_5555;
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk_blank("async_rst");
        bus.load_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_blank("in_rst");
        chk("queue_at_rst", exp_q.size(), 32'd0);
        #1;
        exp_q.delete();
        loads.delete();
        e     = 0;
        rst_i = 1'b1;

        idle_to(2 * FRAME);
        load_at(85, 32'hA5A5_A5A5, 8'h0F, 8'h0A);
        idle_to(4 * FRAME);

        repeat (3) @(posedge clk_i);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
